// File: rtl/fetch_btb_if.sv
// Fetch/BTB bundle: fetch-stage outputs plus execute-stage branch resolution.
// Latency: none (wires only).
// Backpressure: stall_f holds fetch; resolution updates are never back-pressured.
interface fetch_btb_if;
    // Hazard unit hold request.
    logic        stall_f;

    // Branch resolution from execute.
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] upd_correct_pc;

    // Fetch-stage results toward the IF/ID register.
    logic [31:0] pc_f;
    logic [31:0] pcplus4_f;
    logic        branchfound_f;
    logic [31:0] pred_target_f;

    // Predictor side: consumes stall/resolution, produces fetch PC and prediction.
    modport slave (
        input  stall_f,
        input  upd_valid,
        input  upd_pc,
        input  upd_taken,
        input  upd_target,
        input  upd_mispredict,
        input  upd_correct_pc,
        output pc_f,
        output pcplus4_f,
        output branchfound_f,
        output pred_target_f
    );

    // Pipeline side: drives stall/resolution, observes fetch PC and prediction.
    modport master (
        output stall_f,
        output upd_valid,
        output upd_pc,
        output upd_taken,
        output upd_target,
        output upd_mispredict,
        output upd_correct_pc,
        input  pc_f,
        input  pcplus4_f,
        input  branchfound_f,
        input  pred_target_f
    );
endinterface

// File: rtl/fetch_btb_predictor.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit saturating direction counters.
// Latency: prediction is combinational on pc_f; redirects and predicted targets land next cycle.
// Backpressure: stall_f holds pc_f unless a mispredict redirect arrives; BTB updates ignore stall.
module fetch_btb_predictor #(
    parameter int          ENTRIES  = 16,
    parameter int          IDX_W    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic       clk,
    input  logic       reset,
    fetch_btb_if.slave bus
);

    localparam int TAG_W = 32 - IDX_W - 2;

    // Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
    localparam logic [1:0] CTR_RESET = 2'b01;
    localparam logic [1:0] CTR_ALLOC = 2'b10;
    localparam logic [1:0] CTR_MAX   = 2'b11;
    localparam logic [1:0] CTR_MIN   = 2'b00;

    // Saturating step of a direction counter toward the resolved outcome.
    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
        logic [1:0] res;
        res = ctr;
        if (taken) begin
            if (ctr != CTR_MAX) res = ctr + 2'd1;
        end else begin
            if (ctr != CTR_MIN) res = ctr - 2'd1;
        end
        return res;
    endfunction

    // Index and tag extraction; the two byte-offset bits never take part.
    function automatic logic [IDX_W-1:0] pc_idx(input logic [31:0] pc);
        return pc[IDX_W+1:2];
    endfunction

    function automatic logic [TAG_W-1:0] pc_tag(input logic [31:0] pc);
        return pc[31:IDX_W+2];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [31:0]      pc_q;
    logic [31:0]      pc_d;

    logic             valid_q [ENTRIES];
    logic [1:0]       ctr_q   [ENTRIES];
    logic [TAG_W-1:0] tag_q   [ENTRIES];
    logic [31:0]      tgt_q   [ENTRIES];

    // ------------------------------------------------------------------
    // Fetch-side lookup
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;
    logic             f_taken;
    logic [31:0]      f_pcplus4;

    assign f_idx     = pc_idx(pc_q);
    assign f_tag     = pc_tag(pc_q);
    assign f_hit     = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_taken   = f_hit && ctr_q[f_idx][1];
    assign f_pcplus4 = pc_q + 32'd4;

    // ------------------------------------------------------------------
    // Update-side decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] u_idx;
    logic [TAG_W-1:0] u_tag;
    logic             u_hit;
    logic             u_alloc;
    logic             u_ctr_we;
    logic             u_tgt_we;
    logic [1:0]       u_ctr_d;
    logic             redirect;

    // Byte-offset bits of the resolved PC carry no BTB information.
    logic [1:0]       unused_upd_pc_lsbs;
    assign unused_upd_pc_lsbs = bus.upd_pc[1:0];

    assign u_idx    = pc_idx(bus.upd_pc);
    assign u_tag    = pc_tag(bus.upd_pc);
    assign redirect = bus.upd_valid && bus.upd_mispredict;

    // Decide whether the resolved branch trains an existing entry or claims the slot.
    always_comb begin
        u_hit    = 1'b0;
        u_alloc  = 1'b0;
        u_ctr_we = 1'b0;
        u_tgt_we = 1'b0;
        u_ctr_d  = ctr_q[u_idx];
        if (bus.upd_valid) begin
            u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
            if (u_hit) begin
                u_ctr_we = 1'b1;
                u_tgt_we = bus.upd_taken;
                u_ctr_d  = ctr_step(ctr_q[u_idx], bus.upd_taken);
            end else if (bus.upd_taken) begin
                // Replacement: the new branch evicts whatever lived at this index.
                u_alloc  = 1'b1;
                u_ctr_we = 1'b1;
                u_tgt_we = 1'b1;
                u_ctr_d  = CTR_ALLOC;
            end
        end
    end

    // Next fetch PC: mispredict redirect beats stall, stall beats prediction.
    always_comb begin
        pc_d = f_pcplus4;
        if (redirect) begin
            pc_d = bus.upd_correct_pc;
        end else if (bus.stall_f) begin
            pc_d = pc_q;
        end else if (f_taken) begin
            pc_d = tgt_q[f_idx];
        end
    end

    // PC register; reset takes effect immediately, not at the next edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Valid bits and counters; lookup reads pre-update values, writes land next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= CTR_RESET;
            end
        end else begin
            if (u_alloc) begin
                valid_q[u_idx] <= 1'b1;
            end
            if (u_ctr_we) begin
                ctr_q[u_idx] <= u_ctr_d;
            end
        end
    end

    // Tags and targets are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (u_alloc) begin
            tag_q[u_idx] <= u_tag;
        end
        if (u_tgt_we) begin
            tgt_q[u_idx] <= bus.upd_target;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc_f          = pc_q;
    assign bus.pcplus4_f     = f_pcplus4;
    assign bus.branchfound_f = f_taken;
    assign bus.pred_target_f = tgt_q[f_idx];

endmodule

// File: tb/tb_fetch_btb_predictor.sv
module tb_fetch_btb_predictor;

    localparam int NENT = 16;

    logic clk;
    logic reset;

    fetch_btb_if bus ();

    fetch_btb_predictor #(
        .ENTRIES (NENT),
        .IDX_W   (4),
        .RESET_PC(32'h0)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed vector table: inputs held for one cycle, outputs expected after the edge.
    // ------------------------------------------------------------------
    typedef struct {
        bit          stall;
        bit          uv;
        logic [31:0] upc;
        bit          tk;
        logic [31:0] tgt;
        bit          mp;
        logic [31:0] cpc;
        logic [31:0] e_pc;
        bit          e_bf;
        logic [31:0] e_tgt;
    } vec_t;

    function automatic vec_t mk(bit stall, bit uv, logic [31:0] upc, bit tk, logic [31:0] tgt,
                                bit mp, logic [31:0] cpc, logic [31:0] e_pc, bit e_bf,
                                logic [31:0] e_tgt);
        vec_t v;
        v.stall = stall; v.uv = uv; v.upc = upc; v.tk = tk; v.tgt = tgt;
        v.mp = mp; v.cpc = cpc; v.e_pc = e_pc; v.e_bf = e_bf; v.e_tgt = e_tgt;
        return v;
    endfunction

    task automatic drive(input bit stall, input bit uv, input logic [31:0] upc, input bit tk,
                         input logic [31:0] tgt, input bit mp, input logic [31:0] cpc);
        bus.stall_f        = stall;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_taken      = tk;
        bus.upd_target     = tgt;
        bus.upd_mispredict = mp;
        bus.upd_correct_pc = cpc;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: BTB as plain arrays, indices from integer division.
    // ------------------------------------------------------------------
    bit          m_valid [NENT];
    logic [31:0] m_tag   [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_ctr   [NENT];
    logic [31:0] m_pc;

    function automatic int m_index(input logic [31:0] pc);
        return int'((pc / 32'd4) % NENT);
    endfunction

    function automatic logic [31:0] m_tagof(input logic [31:0] pc);
        return pc / (32'd4 * NENT);
    endfunction

    function automatic bit m_predict_taken();
        int i;
        i = m_index(m_pc);
        return m_valid[i] && (m_tag[i] == m_tagof(m_pc)) && (m_ctr[i] >= 2);
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 1'b0;
            m_ctr[i]   = 1;
            m_tag[i]   = '0;
            m_tgt[i]   = '0;
        end
        m_pc = 32'h0;
    endtask

    // Advance the model by one clock using the inputs currently on the bus.
    task automatic m_step();
        logic [31:0] nxt;
        int ui;
        if (bus.upd_valid && bus.upd_mispredict) nxt = bus.upd_correct_pc;
        else if (bus.stall_f)                    nxt = m_pc;
        else if (m_predict_taken())              nxt = m_tgt[m_index(m_pc)];
        else                                     nxt = m_pc + 32'd4;
        if (bus.upd_valid) begin
            ui = m_index(bus.upd_pc);
            if (m_valid[ui] && m_tag[ui] == m_tagof(bus.upd_pc)) begin
                if (bus.upd_taken) begin
                    m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
                    m_tgt[ui] = bus.upd_target;
                end else begin
                    m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                end
            end else if (bus.upd_taken) begin
                m_valid[ui] = 1'b1;
                m_tag[ui]   = m_tagof(bus.upd_pc);
                m_tgt[ui]   = bus.upd_target;
                m_ctr[ui]   = 2;
            end
        end
        m_pc = nxt;
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p;
        p = 32'($urandom_range(0, 127)) * 32'd4;
        if ($urandom_range(0, 7) == 0) p = p + 32'($urandom_range(1, 3));
        return p;
    endfunction

    vec_t tbl [25];

    initial begin
        // Sequential walk, allocation, saturation, alias, stall/redirect, no-bypass, wrap.
        tbl[0]  = mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'h4,        0, 32'h0);
        tbl[1]  = mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'h8,        0, 32'h0);
        tbl[2]  = mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'hC,        0, 32'h0);
        tbl[3]  = mk(0, 1, 32'h10,  1, 32'h80, 0, 32'h0,        32'h10,       1, 32'h80);
        tbl[4]  = mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'h80,       0, 32'h0);
        tbl[5]  = mk(0, 1, 32'h10,  1, 32'h80, 0, 32'h0,        32'h84,       0, 32'h0);
        tbl[6]  = mk(0, 1, 32'h10,  1, 32'h80, 0, 32'h0,        32'h88,       0, 32'h0);
        tbl[7]  = mk(0, 1, 32'h10,  1, 32'h80, 0, 32'h0,        32'h8C,       0, 32'h0);
        tbl[8]  = mk(0, 1, 32'h10,  0, 32'h0,  1, 32'h10,       32'h10,       1, 32'h80);
        tbl[9]  = mk(0, 1, 32'h10,  0, 32'h0,  1, 32'h10,       32'h10,       0, 32'h0);
        tbl[10] = mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'h14,       0, 32'h0);
        tbl[11] = mk(0, 1, 32'h10,  1, 32'h80, 0, 32'h0,        32'h18,       0, 32'h0);
        tbl[12] = mk(0, 1, 32'h50,  0, 32'h0,  1, 32'h50,       32'h50,       0, 32'h0);
        tbl[13] = mk(0, 1, 32'h300, 0, 32'h0,  1, 32'h10,       32'h10,       1, 32'h80);
        tbl[14] = mk(1, 1, 32'h300, 0, 32'h0,  1, 32'h200,      32'h200,      0, 32'h0);
        tbl[15] = mk(1, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'h200,      0, 32'h0);
        tbl[16] = mk(1, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'h200,      0, 32'h0);
        tbl[17] = mk(1, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'h200,      0, 32'h0);
        tbl[18] = mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'h204,      0, 32'h0);
        tbl[19] = mk(0, 0, 32'h0,   0, 32'h0,  1, 32'h400,      32'h208,      0, 32'h0);
        tbl[20] = mk(0, 1, 32'h300, 0, 32'h0,  1, 32'h10,       32'h10,       1, 32'h80);
        tbl[21] = mk(0, 1, 32'h10,  0, 32'h0,  0, 32'h0,        32'h80,       0, 32'h0);
        tbl[22] = mk(0, 1, 32'h300, 0, 32'h0,  1, 32'h10,       32'h10,       0, 32'h0);
        tbl[23] = mk(0, 1, 32'h300, 0, 32'h0,  1, 32'hFFFFFFFC, 32'hFFFFFFFC, 0, 32'h0);
        tbl[24] = mk(0, 0, 32'h0,   0, 32'h0,  0, 32'h0,        32'h0,        0, 32'h0);

        // ---------------- reset state ----------------
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #3;
        check("reset_pc", bus.pc_f, 32'h0);
        check("reset_bf", 32'(bus.branchfound_f), 32'h0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        // One edge passed with reset low and idle inputs: PC advanced once.
        check("first_pc", bus.pc_f, 32'h4);
        reset = 1'b1;
        #2;
        reset = 1'b0;
        check("rereset_pc", bus.pc_f, 32'h0);
        check("rereset_pc4", bus.pcplus4_f, 32'h4);

        // ---------------- directed table ----------------
        for (int r = 0; r < 25; r++) begin
            drive(tbl[r].stall, tbl[r].uv, tbl[r].upc, tbl[r].tk, tbl[r].tgt, tbl[r].mp, tbl[r].cpc);
            tick();
            check($sformatf("vec%0d_pc", r), bus.pc_f, tbl[r].e_pc);
            check($sformatf("vec%0d_pc4", r), bus.pcplus4_f, tbl[r].e_pc + 32'd4);
            check($sformatf("vec%0d_bf", r), 32'(bus.branchfound_f), 32'(tbl[r].e_bf));
            if (tbl[r].e_bf)
                check($sformatf("vec%0d_tgt", r), bus.pred_target_f, tbl[r].e_tgt);
        end

        // ---------------- async reset mid-operation ----------------
        drive(0, 1, 32'h10, 1, 32'h80, 1, 32'h10);
        tick();
        check("pre_rst_pc", bus.pc_f, 32'h10);
        check("pre_rst_bf", 32'(bus.branchfound_f), 32'h1);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_pc", bus.pc_f, 32'h0);
        check("async_rst_bf", 32'(bus.branchfound_f), 32'h0);
        #2;
        reset = 1'b0;
        drive(0, 1, 32'h300, 0, 32'h0, 1, 32'h10);
        tick();
        check("post_rst_pc", bus.pc_f, 32'h10);
        check("post_rst_bf", 32'(bus.branchfound_f), 32'h0);
        drive(0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
        tick();
        check("post_rst_seq", bus.pc_f, 32'h14);

        // ---------------- randomized run against the model ----------------
        reset = 1'b1;
        #2;
        reset = 1'b0;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 4) == 0,
                  $urandom_range(0, 2) != 0,
                  rnd_pc(),
                  $urandom_range(0, 1) == 1,
                  rnd_pc(),
                  $urandom_range(0, 3) == 0,
                  rnd_pc());
            check("rnd_pc", bus.pc_f, m_pc);
            check("rnd_pc4", bus.pcplus4_f, m_pc + 32'd4);
            check("rnd_bf", 32'(bus.branchfound_f), 32'(m_predict_taken()));
            if (m_predict_taken())
                check("rnd_tgt", bus.pred_target_f, m_tgt[m_index(m_pc)]);
            m_step();
            tick();
        end
        check("rnd_final_pc", bus.pc_f, m_pc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
